// File: rtl/rv32_register_file.sv
// ---------------------------------------------------------------------------
// rv32_register_file
//
// RISC-V integer register file for the single-cycle RISCV_CPU. It holds
// 2**ADDR_WIDTH registers of DATA_WIDTH bits. It has two combinational read
// ports and one synchronous write port. With ZERO_REG_HARDWIRED set,
// register 0 reads as zero and ignores writes, which models RISC-V x0.
//
// Ports
//   clk            system clock; all state updates on the rising edge
//   rst            synchronous, active-high reset; clears every register
//   regWrite       write enable
//   readRegister1  index for read port 1
//   readRegister2  index for read port 2
//   writeRegister  index for the write port
//   writeData      data to write
//   readData1      contents of readRegister1 (zero latency)
//   readData2      contents of readRegister2 (zero latency)
// ---------------------------------------------------------------------------
module rv32_register_file #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 5,
  parameter int ZERO_REG_HARDWIRED = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  regWrite,
  input  logic [ADDR_WIDTH-1:0] readRegister1,
  input  logic [ADDR_WIDTH-1:0] readRegister2,
  input  logic [ADDR_WIDTH-1:0] writeRegister,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam bit HARD_ZERO = (ZERO_REG_HARDWIRED != 0);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  // Each register carries its own address decode. If writeRegister contains
  // X/Z, every equality compare evaluates to X. The if then takes its false
  // branch, so the write is dropped and no register is corrupted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rst) begin
        // NOTE: the storage is cleared by a loop on reset. This is a flop
        // array, not a RAM macro. A RAM could not clear every word in a
        // single edge.
        regs[i] <= '0;
      end else if (regWrite && (writeRegister == ADDR_WIDTH'(i))
                   && !(HARD_ZERO && i == 0)) begin
        // NOTE: state is updated with non-blocking assignments. Readers on
        // the same edge therefore see the old value, which gives the
        // no-bypass read-during-write behaviour.
        regs[i] <= writeData;
      end
    end
  end

  // The read ports have no bypass. A same-cycle write becomes visible only
  // after the edge.
  always_comb begin
    // NOTE: both outputs are assigned on every path. An unassigned path
    // would infer a latch.
    readData1 = regs[readRegister1];
    readData2 = regs[readRegister2];
    if (HARD_ZERO && readRegister1 == '0) readData1 = '0;
    if (HARD_ZERO && readRegister2 == '0) readData2 = '0;
  end

endmodule

// File: tb/tb_rv32_register_file.sv
// ---------------------------------------------------------------------------
// tb_rv32_register_file
//
// Self-checking bench for rv32_register_file. Inputs are driven on the
// falling edge. Combinational reads are sampled 1 time unit later, well away
// from the rising edge. The reference model is a plain array. Entry 0 of the
// array stays zero, and the array is updated after each rising edge using
// the architectural rules.
// ---------------------------------------------------------------------------
module tb_rv32_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          regWrite;
  logic [AW-1:0] readRegister1;
  logic [AW-1:0] readRegister2;
  logic [AW-1:0] writeRegister;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData1;
  logic [DW-1:0] readData2;

  logic [DW-1:0] model [NR];
  int passCount = 0;
  int checkCount = 0;

  rv32_register_file #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .ZERO_REG_HARDWIRED(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .regWrite(regWrite),
    .readRegister1(readRegister1),
    .readRegister2(readRegister2),
    .writeRegister(writeRegister),
    .writeData(writeData),
    .readData1(readData1),
    .readData2(readData2)
  );

  always #5 clk = ~clk;

  // Cross one rising edge, then return at the next falling edge.
  task automatic stepEdge();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Architectural effect of one rising edge on the model.
  task automatic modelEdge(input logic r, input logic we,
                           input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    if (r) begin
      for (int i = 0; i < NR; i++) model[i] = '0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; regWrite = 1'b0;
    stepEdge();
    modelEdge(1'b1, 1'b0, '0, '0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      readRegister1 = AW'(i);
      readRegister2 = AW'(i + 1);
      #1;
      checkCount++;
      if (readData1 !== 32'h0) $display("FAIL reset_rd1[%0d] got %h want 00000000", i, readData1);
      else passCount++;
      checkCount++;
      if (readData2 !== 32'h0) $display("FAIL reset_rd2[%0d] got %h want 00000000", i + 1, readData2);
      else passCount++;
      @(negedge clk);
    end
  endtask

  task automatic test_write_sweep();
    regWrite = 1'b1;
    for (int i = 0; i < 16; i++) begin
      writeRegister = AW'(i);
      writeData = DW'(i + 1);
      stepEdge();
      modelEdge(1'b0, 1'b1, AW'(i), DW'(i + 1));
    end
    regWrite = 1'b0;
    for (int i = 0; i < 16; i++) begin
      readRegister1 = AW'(i);
      readRegister2 = AW'(i + 1);
      #1;
      checkCount++;
      if (readData1 !== model[i]) $display("FAIL sweep_rd1[%0d] got %h want %h", i, readData1, model[i]);
      else passCount++;
      checkCount++;
      if (readData2 !== model[i + 1]) $display("FAIL sweep_rd2[%0d] got %h want %h", i + 1, readData2, model[i + 1]);
      else passCount++;
      @(negedge clk);
    end
  endtask

  task automatic test_write_disable();
    regWrite = 1'b0; writeRegister = 5'd5; writeData = 32'h12345678;
    stepEdge();
    modelEdge(1'b0, 1'b0, 5'd5, 32'h12345678);
    readRegister1 = 5'd5;
    #1;
    checkCount++;
    if (readData1 !== 32'd6) $display("FAIL write_disable x5 got %h want 00000006", readData1);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_x0();
    regWrite = 1'b1; writeRegister = 5'd0; writeData = 32'hFFFFFFFF;
    stepEdge();
    modelEdge(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF);
    regWrite = 1'b0;
    readRegister1 = 5'd0; readRegister2 = 5'd0;
    #1;
    checkCount++;
    if (readData1 !== 32'h0) $display("FAIL x0_rd1 got %h want 00000000", readData1);
    else passCount++;
    checkCount++;
    if (readData2 !== 32'h0) $display("FAIL x0_rd2 got %h want 00000000", readData2);
    else passCount++;
    @(negedge clk);
  endtask

  task automatic test_read_during_write();
    readRegister1 = 5'd7; readRegister2 = 5'd7;
    writeRegister = 5'd7; writeData = 32'hDEADBEEF; regWrite = 1'b1;
    #1;
    checkCount++;
    if (readData1 !== 32'd8) $display("FAIL rdw_before rd1 got %h want 00000008", readData1);
    else passCount++;
    checkCount++;
    if (readData2 !== 32'd8) $display("FAIL rdw_before rd2 got %h want 00000008", readData2);
    else passCount++;
    @(posedge clk);
    modelEdge(1'b0, 1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    checkCount++;
    if (readData1 !== 32'hDEADBEEF) $display("FAIL rdw_after rd1 got %h want deadbeef", readData1);
    else passCount++;
    checkCount++;
    if (readData2 !== 32'hDEADBEEF) $display("FAIL rdw_after rd2 got %h want deadbeef", readData2);
    else passCount++;
    @(negedge clk);
    regWrite = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      regWrite      = 1'($urandom_range(0, 1));
      writeRegister = AW'($urandom_range(0, NR - 1));
      writeData     = $urandom();
      readRegister1 = AW'($urandom_range(0, NR - 1));
      // Sometimes aim read port 2 at the register being written.
      readRegister2 = ($urandom_range(0, 3) == 0) ? writeRegister
                                                  : AW'($urandom_range(0, NR - 1));
      #1;
      checkCount++;
      if (readData1 !== model[readRegister1])
        $display("FAIL rand_rd1[%0d] x%0d got %h want %h", n, readRegister1, readData1, model[readRegister1]);
      else passCount++;
      checkCount++;
      if (readData2 !== model[readRegister2])
        $display("FAIL rand_rd2[%0d] x%0d got %h want %h", n, readRegister2, readData2, model[readRegister2]);
      else passCount++;
      @(posedge clk);
      modelEdge(1'b0, regWrite, writeRegister, writeData);
      @(negedge clk);
    end
    regWrite = 1'b0;
  endtask

  task automatic test_reset_priority();
    // Make x3 nonzero first, so that clearing it is observable.
    regWrite = 1'b1; writeRegister = 5'd3; writeData = 32'h0BADF00D;
    stepEdge();
    modelEdge(1'b0, 1'b1, 5'd3, 32'h0BADF00D);
    rst = 1'b1; writeData = 32'hA5A5A5A5;
    stepEdge();
    modelEdge(1'b1, 1'b1, 5'd3, 32'hA5A5A5A5);
    rst = 1'b0; regWrite = 1'b0;
    for (int i = 0; i < NR; i++) begin
      readRegister1 = AW'(i);
      readRegister2 = AW'(NR - 1 - i);
      #1;
      checkCount++;
      if (readData1 !== 32'h0) $display("FAIL rst_prio_rd1[%0d] got %h want 00000000", i, readData1);
      else passCount++;
      checkCount++;
      if (readData2 !== 32'h0) $display("FAIL rst_prio_rd2[%0d] got %h want 00000000", NR - 1 - i, readData2);
      else passCount++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; regWrite = 1'b0;
    readRegister1 = '0; readRegister2 = '0;
    writeRegister = '0; writeData = '0;
    for (int i = 0; i < NR; i++) model[i] = '0;
    @(negedge clk);
    test_reset();
    test_write_sweep();
    test_write_disable();
    test_x0();
    test_read_during_write();
    test_random();
    test_reset_priority();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
